// File: rtl/button_conditioner_if.sv
// Button/increment bundle between the raw switch inputs and the clock/LCD block.
interface button_conditioner_if;
    logic btn_hour;
    logic btn_min;
    logic hour_inc;
    logic min_inc;

    modport master (output btn_hour, output btn_min, input hour_inc, input min_inc);
    modport slave  (input btn_hour, input btn_min, output hour_inc, output min_inc);
endinterface

// File: rtl/button_conditioner.sv
// Two-channel button synchronizer/debouncer with press pulses and optional auto-repeat.
// Auto-repeat (and the both-held repeat lockout) is built only with BUTTON_AUTOREPEAT_EN defined.
module button_conditioner_chan #(
    parameter int DEB_CYC        = 20,
`ifdef BUTTON_AUTOREPEAT_EN
    parameter int RD_CYC         = 500,
    parameter int RP_CYC         = 200,
`endif
    parameter bit BTN_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
`ifdef BUTTON_AUTOREPEAT_EN
    input  logic suppress_i,
    output logic active_o,
`endif
    output logic inc_o
);
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYC - 1);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [15:0] RD_LAST  = 16'(RD_CYC - 1);
    localparam logic [15:0] RP_LAST  = 16'(RP_CYC - 1);
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2} state_e;

    logic [1:0]  sync_q;
    logic        s;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    logic        d_q, d_d;
    state_e      state_q, state_d;
    logic        inc_q, inc_d;
`ifdef BUTTON_AUTOREPEAT_EN
    logic [15:0] tmr_q, tmr_d;
`endif

    assign s = sync_q[1] ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= {2{BTN_ACTIVE_LOW}};
            deb_cnt_q <= '0;
            d_q       <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            deb_cnt_q <= deb_cnt_d;
            d_q       <= d_d;
        end
    end

    // The level only moves after s has disagreed with it for DEB_CYC consecutive cycles.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        d_d       = d_q;
        if (s == d_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            d_d       = s;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            inc_q   <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            tmr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
`ifdef BUTTON_AUTOREPEAT_EN
            tmr_q   <= tmr_d;
`endif
        end
    end

    // The repeat timer clears on every terminal count, so it is bounded and never wraps.
    always_comb begin
        state_d = state_q;
`ifdef BUTTON_AUTOREPEAT_EN
        tmr_d   = tmr_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_q) state_d = HELD;
`ifdef BUTTON_AUTOREPEAT_EN
                tmr_d = '0;
`endif
            end
            HELD: begin
                if (!d_q) state_d = IDLE;
`ifdef BUTTON_AUTOREPEAT_EN
                else if (suppress_i) tmr_d = '0;
                else if (tmr_q == RD_LAST) begin
                    state_d = REPEAT;
                    tmr_d   = '0;
                end else tmr_d = tmr_q + 16'd1;
`endif
            end
`ifdef BUTTON_AUTOREPEAT_EN
            REPEAT: begin
                if (!d_q) state_d = IDLE;
                else if (suppress_i) begin
                    state_d = HELD;
                    tmr_d   = '0;
                end else if (tmr_q == RP_LAST) tmr_d = '0;
                else tmr_d = tmr_q + 16'd1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inc_d = 1'b0;
        case (state_q)
            IDLE:   inc_d = d_q;
`ifdef BUTTON_AUTOREPEAT_EN
            HELD:   inc_d = d_q && !suppress_i && (tmr_q == RD_LAST);
            REPEAT: inc_d = d_q && !suppress_i && (tmr_q == RP_LAST);
`endif
            default: inc_d = 1'b0;
        endcase
    end

`ifdef BUTTON_AUTOREPEAT_EN
    assign active_o = (state_q != IDLE);
`endif
    assign inc_o = inc_q;
endmodule

module button_conditioner #(
    parameter int CLOCK_RATE       = 1000,
    parameter int DEBOUNCE_MS      = 20,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_PERIOD_MS = 200,
    parameter bit BTN_ACTIVE_LOW   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    button_conditioner_if.slave bus
);
    localparam int DEB_CYC = CLOCK_RATE * DEBOUNCE_MS / 1000;
    localparam int RD_CYC  = CLOCK_RATE * REPEAT_DELAY_MS / 1000;
    localparam int RP_CYC  = CLOCK_RATE * REPEAT_PERIOD_MS / 1000;
    // An out-of-range configuration leaves the outputs dead instead of silently truncating timers.
    localparam bit CFG_OK  = (DEB_CYC >= 1) && (DEB_CYC <= 65535) &&
                             (RD_CYC  >= 2) && (RD_CYC  <= 65535) &&
                             (RP_CYC  >= 2) && (RP_CYC  <= 65535);

    logic [1:0] btn;
    logic [1:0] inc;
`ifdef BUTTON_AUTOREPEAT_EN
    logic [1:0] act;
    logic       both_held;
    assign both_held = &act;
`endif

    assign btn = {bus.btn_min, bus.btn_hour};

    for (genvar i = 0; i < 2; i++) begin : g_chan
        button_conditioner_chan #(
            .DEB_CYC        (DEB_CYC),
`ifdef BUTTON_AUTOREPEAT_EN
            .RD_CYC         (RD_CYC),
            .RP_CYC         (RP_CYC),
`endif
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .btn_i      (btn[i]),
`ifdef BUTTON_AUTOREPEAT_EN
            .suppress_i (both_held),
            .active_o   (act[i]),
`endif
            .inc_o      (inc[i])
        );
    end

    assign bus.hour_inc = inc[0] & CFG_OK;
    assign bus.min_inc  = inc[1] & CFG_OK;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench: spec-constant vector table, hand sequences, and random stimulus against an event model.
module tb_button_conditioner;
    localparam int DEB = 20;
    localparam int RD  = 500;
    localparam int RP  = 200;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] raw = 2'b00;   // [0]=hour, [1]=min, 1 = pressed
    always #5 clk = ~clk;

    button_conditioner_if bus0();
    button_conditioner_if bus1();
    assign bus0.btn_hour = raw[0];
    assign bus0.btn_min  = raw[1];
    assign bus1.btn_hour = ~raw[0];
    assign bus1.btn_min  = ~raw[1];

    button_conditioner u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    button_conditioner #(.BTN_ACTIVE_LOW(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int rel    = 0;

    // reference model state, per channel
    bit sy1[2], sy2[2], md[2], mact[2], exp_o[2];
    int mism[2], anchor[2];

    // pulse bookkeeping for the current sequence
    int cnt_h0, cnt_m0, cnt_h1, cnt_m1, first_p, last_p;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d want %0d", nm, edge_n, got, want);
        end
    endtask

    task automatic model_step();
        bit both;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                sy1[c] = 0; sy2[c] = 0; md[c] = 0; mact[c] = 0;
                mism[c] = 0; anchor[c] = 0; exp_o[c] = 0;
            end
            return;
        end
        both = mact[0] && mact[1];
        for (int c = 0; c < 2; c++) begin
            bit p;
            int k;
            p = 0;
            if (!mact[c]) begin
                if (md[c]) begin mact[c] = 1; anchor[c] = edge_n; p = 1; end
            end else if (!md[c]) begin
                mact[c] = 0;
            end else if (AR) begin
                if (both) anchor[c] = edge_n;
                else begin
                    k = edge_n - anchor[c];
                    if (k >= RD && ((k - RD) % RP) == 0) p = 1;
                end
            end
            exp_o[c] = p;
            if (sy2[c] != md[c]) begin
                mism[c]++;
                if (mism[c] == DEB) begin md[c] = sy2[c]; mism[c] = 0; end
            end else mism[c] = 0;
            sy2[c] = sy1[c];
            sy1[c] = raw[c];
        end
    endtask

    task automatic clear_counts();
        cnt_h0 = 0; cnt_m0 = 0; cnt_h1 = 0; cnt_m1 = 0;
        first_p = -1; last_p = -1; rel = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        rel++;
        model_step();
        #1;
        check("hour0", bus0.hour_inc, exp_o[0]);
        check("min0",  bus0.min_inc,  exp_o[1]);
        check("hour1", bus1.hour_inc, exp_o[0]);
        check("min1",  bus1.min_inc,  exp_o[1]);
        if (bus0.hour_inc === 1'b1) cnt_h0++;
        if (bus0.min_inc  === 1'b1) cnt_m0++;
        if (bus1.hour_inc === 1'b1) cnt_h1++;
        if (bus1.min_inc  === 1'b1) cnt_m1++;
        if (bus0.hour_inc === 1'b1 || bus0.min_inc === 1'b1) begin
            if (first_p < 0) first_p = rel;
            last_p = rel;
        end
    endtask

    typedef struct {
        string nm;
        int    h_len;
        int    m_len;
        int    run;
        int    exp_h;
        int    exp_m;
        int    exp_first;
        int    exp_last;
    } vec_t;

    vec_t vecs[7];
    int   rem[2];

    initial begin
        vecs[0] = '{"min100",   0,   100,  150,  0,            1, 23, 23};
        vecs[1] = '{"hour19",   19,  0,    80,   0,            0, -1, -1};
        vecs[2] = '{"hour20",   20,  0,    80,   1,            0, 23, 23};
        vecs[3] = '{"hour1",    1,   0,    40,   0,            0, -1, -1};
        vecs[4] = '{"hour1200", 1200,0,    1260, AR ? 5 : 1,   0, 23, AR ? 1123 : 23};
        vecs[5] = '{"both1000", 1000,1000, 1060, 1,            1, 23, 23};
        vecs[6] = '{"hour50",   50,  0,    100,  1,            0, 23, 23};

        reset = 1'b1;
        raw   = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        check("rst_hour", bus0.hour_inc, 1'b0);
        check("rst_min",  bus0.min_inc,  1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        foreach (vecs[v]) begin
            clear_counts();
            raw[0] = (vecs[v].h_len > 0);
            raw[1] = (vecs[v].m_len > 0);
            for (int i = 1; i <= vecs[v].run; i++) begin
                tick();
                if (i == vecs[v].h_len) raw[0] = 1'b0;
                if (i == vecs[v].m_len) raw[1] = 1'b0;
            end
            check({vecs[v].nm, "_nh0"},   cnt_h0,  vecs[v].exp_h);
            check({vecs[v].nm, "_nm0"},   cnt_m0,  vecs[v].exp_m);
            check({vecs[v].nm, "_nh1"},   cnt_h1,  vecs[v].exp_h);
            check({vecs[v].nm, "_nm1"},   cnt_m1,  vecs[v].exp_m);
            check({vecs[v].nm, "_first"}, first_p, vecs[v].exp_first);
            check({vecs[v].nm, "_last"},  last_p,  vecs[v].exp_last);
        end

        // 10-on/10-off chatter never survives the debounce
        clear_counts();
        for (int i = 0; i < 200; i++) begin
            raw[0] = ((i / 10) % 2) == 0;
            tick();
        end
        raw[0] = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("chatter_h0", cnt_h0, 0);
        check("chatter_h1", cnt_h1, 0);

        // reset pulse mid-hold: aborts, then the still-held button re-presses
        clear_counts();
        raw[1] = 1'b1;
        for (int i = 1; i <= 1190; i++) begin
            reset = (i == 600);
            tick();
            if (i == 600) check("rst_mid_min0", bus0.min_inc, 1'b0);
            if (i == 623) check("repress_623", bus0.min_inc, 1'b1);
            if (i == 1150) raw[1] = 1'b0;
        end
        reset = 1'b0;
        check("rstmid_cnt", cnt_m0, AR ? 4 : 2);
        check("rstmid_last", last_p, AR ? 1123 : 623);

        // random holds and chatter, with occasional resets
        rem[0] = 0;
        rem[1] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (rem[c] == 0) begin
                    raw[c] = ~raw[c];
                    rem[c] = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 40))
                                                        : int'($urandom_range(40, 900));
                end
                rem[c]--;
            end
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0;
        raw   = 2'b00;
        for (int i = 0; i < 40; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
